pshare_predictor: RTL
=====================

Name: pshare_predictor

Overview:
Parametrised per-address-history (pshare) branch predictor. A Branch History Table (BHT) of per-PC local histories is XORed with PC bits to index a Pattern History Table (PHT) of 2-bit saturating counters. Separate predict and update ports, a sequential table-init sweep after reset, and saturating accuracy statistics. Sits in the front-end next to the fetch PC; driven from the branch-resolve stage.

Parameters:
ADDR_W, 32, PC width.
BHT_IDX_W, 4, log2 BHT entries; BHT index = pc[BHT_IDX_W+1:2].
HIST_W, 4, local history bits per BHT entry; must satisfy HIST_W <= PHT_IDX_W.
PHT_IDX_W, 6, log2 PHT entries; PHT index = pc[PHT_IDX_W+1:2] XOR zero-extended history.
CNT_W, 32, statistics counter width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
ready  out  1  high once the init sweep is complete
pred_req  in  1  prediction request
pred_pc  in  ADDR_W  PC to predict
pred_vld  out  1  pred_taken valid (1 cycle after pred_req)
pred_taken  out  1  MSB of the selected PHT counter
upd_vld  in  1  resolved-branch update
upd_pc  in  ADDR_W  resolved branch PC
upd_taken  in  1  actual outcome
total_branch  out  CNT_W  updates accepted
mispredict  out  CNT_W  updates whose counter MSB != upd_taken

Behaviour:
- Reset (reset==0 at posedge):
  - FSM enters INIT.
  - ready=0, pred_vld=0, pred_taken=0, total_branch=0, mispredict=0.
  - Reset asserted mid-operation aborts everything and restarts INIT.
- FSM INIT:
  - Sweep pointer p runs 0..max(2^BHT_IDX_W, 2^PHT_IDX_W)-1, one entry per cycle.
  - Each cycle writes BHT[p]=0 (if p is in range) and PHT[p]=WN (01).
  - After the last entry, go to RUN and set ready=1 on the next cycle (64 cycles at defaults).
  - pred_req and upd_vld are ignored while in INIT: pred_vld stays 0 and stats do not change.
- FSM RUN: stays in RUN until reset.
- Predict:
  - On pred_req in RUN, compute the PHT index from the current BHT entry.
  - Next cycle: pred_vld=1 and pred_taken=PHT[idx][1]. Otherwise pred_vld=0 and pred_taken holds its value.
- Update on upd_vld in RUN, single cycle:
  - h = BHT[upd bht idx]; i = upd_pc[PHT_IDX_W+1:2] ^ h.
  - PHT[i] saturating: taken increments, capped at 11; not-taken decrements, floored at 00.
  - BHT entry becomes {h[HIST_W-2:0], upd_taken}.
  - total_branch increments.
  - mispredict increments if PHT[i][1] != upd_taken, using the pre-update value.
  - Both statistics counters saturate at all-ones.
- Simultaneous predict and update, same cycle: prediction reads pre-update BHT/PHT (read-before-write). The update is never dropped.
- Tables are implemented as flops; no memory-macro timing.

Optional Feature:
PSHARE_STATS_EN:
- Defined: total_branch and mispredict counters are implemented as specified.
- Undefined: no counter flops; both outputs tied to 0. Prediction behaviour is identical.

Decomposition:
- Package pshare_pkg holds:
  - 2-bit state constants SN=00, WN=01, WT=10, ST=11.
  - Function sat2_next(state, taken).
  - Function sat_inc for CNT_W-wide counters.
  - Index-computation function.
- One sub-module, pshare_init_seq: INIT/RUN FSM, sweep pointer, ready flag.

Test Plan:
- Reset release: ready stays 0 for 64 cycles then rises. pred_req/upd_vld issued during INIT give pred_vld=0 and total_branch=0.
- Learning, pc=0x100, 6 updates all taken (PHT idx 0,1,3,7,15,15):
  - Stats end at total_branch=6, mispredict=5.
  - A following predict at 0x100 gives pred_taken=1, one cycle after the request.
- Saturation: 4 further taken updates on PHT idx 15 keep it at ST (11). Then 1 not-taken gives WT; a predict at the resulting history index returns the expected MSB.
- Same-cycle hazard: pred_req and upd_vld both at pc=0x100, with PHT entry at WN and upd_taken=1. Prediction returns 0 (old state); a subsequent predict reflects the new history.
- Reset mid-run after 10 updates: stats become 0 and ready=0 the next cycle. After 64 cycles a predict at any PC returns 0 (all WN).
- With CNT_W=8 and PSHARE_STATS_EN, 300 updates give total_branch=255 (saturated). Without the macro, both stats outputs read 0.

Source files
------------

// File: rtl/pshare_pkg.sv
// Shared types, counter constants and helper functions for the pshare branch predictor.
package pshare_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_state_e;

    localparam logic [1:0] SN = 2'b00;
    localparam logic [1:0] WN = 2'b01;
    localparam logic [1:0] WT = 2'b10;
    localparam logic [1:0] ST = 2'b11;

    function automatic logic [1:0] sat2_next(input logic [1:0] state, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (state == ST) ? ST : state + 2'd1;
        end else begin
            nxt = (state == SN) ? SN : state - 2'd1;
        end
        return nxt;
    endfunction

    // Callers zero-extend to 64 bits and truncate the result back to their counter width.
    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input logic [63:0] max_val);
        logic [63:0] nxt;
        if (cnt == max_val) begin
            nxt = cnt;
        end else begin
            nxt = cnt + 64'd1;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] pht_index(input logic [63:0] pc, input logic [31:0] hist,
                                              input int idx_w);
        logic [31:0] pc_bits;
        logic [31:0] mask;
        pc_bits = 32'(pc >> 2);
        mask    = (32'd1 << idx_w) - 32'd1;
        return (pc_bits ^ hist) & mask;
    endfunction

endpackage

// File: rtl/pshare_init_seq.sv
// INIT/RUN sequencer: sweeps a table pointer once after reset, then raises ready for good.
module pshare_init_seq
    import pshare_pkg::*;
#(
    parameter int PTR_W = 6
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    output logic             init_we_o,
    output logic [PTR_W-1:0] ptr_o,
    output logic             ready_o
);

    init_state_e      state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             ready_q, ready_d;

    // Next-state logic: ready rises together with the RUN state after the last sweep entry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        case (state_q)
            ST_INIT: begin
                if (ptr_q == {PTR_W{1'b1}}) begin
                    state_d = ST_RUN;
                    ptr_d   = {PTR_W{1'b0}};
                    ready_d = 1'b1;
                end else begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    ready_d = 1'b0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = {PTR_W{1'b0}};
                ready_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= ST_INIT;
            ptr_q   <= {PTR_W{1'b0}};
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
        end
    end

    assign init_we_o = (state_q == ST_INIT) && reset_ni;
    assign ptr_o     = ptr_q;
    assign ready_o   = ready_q;

endmodule

// File: rtl/pshare_predictor.sv
// Per-address-history (pshare) branch predictor with flop-based BHT/PHT tables.
// Optional macro PSHARE_STATS_EN adds saturating total_branch / mispredict counters.
module pshare_predictor
    import pshare_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BHT_IDX_W = 4,
    parameter int HIST_W    = 4,
    parameter int PHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              pred_req,
    input  logic [ADDR_W-1:0] pred_pc,
    output logic              pred_vld,
    output logic              pred_taken,
    input  logic              upd_vld,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    output logic [CNT_W-1:0]  total_branch,
    output logic [CNT_W-1:0]  mispredict
);

    localparam int BHT_N   = 1 << BHT_IDX_W;
    localparam int PHT_N   = 1 << PHT_IDX_W;
    localparam int SWEEP_W = (BHT_IDX_W > PHT_IDX_W) ? BHT_IDX_W : PHT_IDX_W;

    logic [BHT_N-1:0][HIST_W-1:0] bht_q, bht_d;
    logic [PHT_N-1:0][1:0]        pht_q, pht_d;

    logic                 init_we_s;
    logic [SWEEP_W-1:0]   init_ptr_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 bht_in_range_s;
    logic                 pht_in_range_s;
    logic [BHT_IDX_W-1:0] pred_bidx_s, upd_bidx_s;
    logic [HIST_W-1:0]    pred_hist_s, upd_hist_s;
    logic [PHT_IDX_W-1:0] pred_pidx_s, upd_pidx_s;
    logic [1:0]           upd_cnt_s;
    logic                 pred_vld_q, pred_vld_d;
    logic                 pred_taken_q, pred_taken_d;

    pshare_init_seq #(
        .PTR_W(SWEEP_W)
    ) u_init_seq (
        .clk_i    (clk),
        .reset_ni (reset),
        .init_we_o(init_we_s),
        .ptr_o    (init_ptr_s),
        .ready_o  (ready_s)
    );

    // Requests are honoured only in RUN and never in a cycle where reset is being applied.
    assign accept_s       = ready_s & reset;
    assign bht_in_range_s = (init_ptr_s >> BHT_IDX_W) == {SWEEP_W{1'b0}};
    assign pht_in_range_s = (init_ptr_s >> PHT_IDX_W) == {SWEEP_W{1'b0}};

    assign pred_bidx_s = pred_pc[BHT_IDX_W+1:2];
    assign pred_hist_s = bht_q[pred_bidx_s];
    assign pred_pidx_s = PHT_IDX_W'(pht_index(64'(pred_pc), 32'(pred_hist_s), PHT_IDX_W));

    assign upd_bidx_s = upd_pc[BHT_IDX_W+1:2];
    assign upd_hist_s = bht_q[upd_bidx_s];
    assign upd_pidx_s = PHT_IDX_W'(pht_index(64'(upd_pc), 32'(upd_hist_s), PHT_IDX_W));
    assign upd_cnt_s  = pht_q[upd_pidx_s];

    // Table next-state: init sweep has priority, otherwise apply a resolved-branch update.
    always_comb begin
        bht_d = bht_q;
        pht_d = pht_q;
        if (init_we_s) begin
            if (bht_in_range_s) begin
                bht_d[init_ptr_s[BHT_IDX_W-1:0]] = {HIST_W{1'b0}};
            end else begin
                bht_d = bht_q;
            end
            if (pht_in_range_s) begin
                pht_d[init_ptr_s[PHT_IDX_W-1:0]] = WN;
            end else begin
                pht_d = pht_q;
            end
        end else if (accept_s && upd_vld) begin
            bht_d[upd_bidx_s] = HIST_W'({upd_hist_s, upd_taken});
            pht_d[upd_pidx_s] = sat2_next(upd_cnt_s, upd_taken);
        end else begin
            bht_d = bht_q;
            pht_d = pht_q;
        end
    end

    // Table storage needs no reset: the INIT sweep defines every entry before use.
    always_ff @(posedge clk) begin
        bht_q <= bht_d;
        pht_q <= pht_d;
    end

    // Prediction reads the pre-update tables, giving read-before-write on a same-cycle update.
    always_comb begin
        pred_vld_d   = 1'b0;
        pred_taken_d = pred_taken_q;
        if (accept_s && pred_req) begin
            pred_vld_d   = 1'b1;
            pred_taken_d = pht_q[pred_pidx_s][1];
        end else begin
            pred_vld_d   = 1'b0;
            pred_taken_d = pred_taken_q;
        end
    end

    // Prediction output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pred_vld_q   <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            pred_vld_q   <= pred_vld_d;
            pred_taken_q <= pred_taken_d;
        end
    end

    assign ready      = ready_s;
    assign pred_vld   = pred_vld_q;
    assign pred_taken = pred_taken_q;

`ifdef PSHARE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] misp_q, misp_d;
    logic             upd_miss_s;

    assign upd_miss_s = upd_cnt_s[1] ^ upd_taken;

    // Saturating statistics, judged against the counter value before this update.
    always_comb begin
        total_d = total_q;
        misp_d  = misp_q;
        if (accept_s && upd_vld) begin
            total_d = CNT_W'(sat_inc(64'(total_q), 64'(CNT_MAX)));
            if (upd_miss_s) begin
                misp_d = CNT_W'(sat_inc(64'(misp_q), 64'(CNT_MAX)));
            end else begin
                misp_d = misp_q;
            end
        end else begin
            total_d = total_q;
            misp_d  = misp_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            total_q <= {CNT_W{1'b0}};
            misp_q  <= {CNT_W{1'b0}};
        end else begin
            total_q <= total_d;
            misp_q  <= misp_d;
        end
    end

    assign total_branch = total_q;
    assign mispredict   = misp_q;
`else
    assign total_branch = {CNT_W{1'b0}};
    assign mispredict   = {CNT_W{1'b0}};
`endif

endmodule
